// File: rtl/adder_rr_arbiter_if.sv
// Requester/result bundle for adder_rr_arbiter: NREQ packed operand pairs in, one tagged sum out.
// The master drives operands and res_ready; the slave (arbiter) drives grants and the result slot.
interface adder_rr_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  res_valid;
    logic                  res_ready;
    logic [WIDTH-1:0]      res_sum;
    logic                  res_cout;
    logic [IDW-1:0]        res_id;

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_sum, res_cout, res_id
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_sum, res_cout, res_id
    );
endinterface

// File: rtl/adder_rr_arbiter.sv
// Round-robin share of one carry-skip adder; 1-cycle accept-to-result latency, 1 result/cycle.
// Stalled slot (res_valid && !res_ready) blocks all grants; ADDER_ARB_STATS_EN adds per-requester grant counters.
module carry_skip #(
    parameter int width = 32
) (
    input  logic [width-1:0] i_a,
    input  logic [width-1:0] i_b,
    input  logic             i_cin,
    output logic [width-1:0] o_sum,
    output logic             o_cout
);
    localparam int NBLK = width / 4;

    logic w_c;
    logic w_bc;
    logic w_p;
    logic w_all_p;

    // 4-bit ripple blocks; a fully-propagating block forwards its carry-in straight past the ripple chain
    always_comb begin
        o_sum   = '0;
        w_c     = i_cin;
        w_bc    = 1'b0;
        w_p     = 1'b0;
        w_all_p = 1'b0;
        for (int blk = 0; blk < NBLK; blk++) begin
            w_bc    = w_c;
            w_all_p = 1'b1;
            for (int j = 0; j < 4; j++) begin
                w_p                = i_a[blk*4+j] ^ i_b[blk*4+j];
                o_sum[blk*4+j]     = w_p ^ w_c;
                w_c                = (i_a[blk*4+j] & i_b[blk*4+j]) | (w_p & w_c);
                w_all_p            = w_all_p & w_p;
            end
            if (w_all_p) begin
                w_c = w_bc;
            end
        end
        o_cout = w_c;
    end
endmodule

module adder_rr_arbiter #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    adder_rr_arbiter_if.slave    bus
`ifdef ADDER_ARB_STATS_EN
    ,
    input  logic                 stats_clr,
    output logic [NREQ*16-1:0]   grant_cnt
`endif
);
    localparam int IDW = $clog2(NREQ);

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
        $error("adder_rr_arbiter: WIDTH must be a positive multiple of 4");
    end
    if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
        $error("adder_rr_arbiter: NREQ must be in 2..16");
    end

    logic [IDW-1:0]   r_ptr;
    logic             r_res_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic [IDW-1:0]   r_id;

    logic             w_slot_free;
    logic             w_any;
    logic [IDW-1:0]   w_gidx;
    logic [IDW:0]     w_scan;
    logic             w_xfer;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;

    assign w_slot_free = !r_res_valid || bus.res_ready;

    // First valid requester at or above the pointer, wrapping past NREQ-1
    always_comb begin
        w_any  = 1'b0;
        w_gidx = '0;
        w_scan = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_scan = {1'b0, r_ptr} + (IDW+1)'(k);
            if (w_scan >= (IDW+1)'(NREQ)) begin
                w_scan = w_scan - (IDW+1)'(NREQ);
            end
            if (!w_any && bus.req_valid[w_scan[IDW-1:0]]) begin
                w_any  = 1'b1;
                w_gidx = w_scan[IDW-1:0];
            end
        end
    end

    assign w_xfer        = w_any && w_slot_free && rst_n;
    assign bus.req_ready = w_xfer ? (NREQ'(1) << w_gidx) : '0;

    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gidx == IDW'(i)) begin
                w_a = bus.req_a[i*WIDTH +: WIDTH];
                w_b = bus.req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    carry_skip #(.width(WIDTH)) u_add (
        .i_a    (w_a),
        .i_b    (w_b),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_id        <= '0;
            r_ptr       <= '0;
        end else if (w_xfer) begin
            r_res_valid <= 1'b1;
            r_sum       <= w_sum;
            r_cout      <= w_cout;
            r_id        <= w_gidx;
            r_ptr       <= (w_gidx == IDW'(NREQ-1)) ? '0 : w_gidx + 1'b1;
        end else if (bus.res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    assign bus.res_valid = r_res_valid;
    assign bus.res_sum   = r_sum;
    assign bus.res_cout  = r_cout;
    assign bus.res_id    = r_id;

`ifdef ADDER_ARB_STATS_EN
    logic [15:0] r_cnt [NREQ];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (stats_clr) begin
                    r_cnt[i] <= '0;
                end else if (w_xfer && w_gidx == IDW'(i) && r_cnt[i] != 16'hFFFF) begin
                    r_cnt[i] <= r_cnt[i] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant_cnt[i*16 +: 16] = r_cnt[i];
        end
    end
`endif
endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed bench for adder_rr_arbiter with a round-robin reference model and result scoreboard.
module tb_adder_rr_arbiter;
    localparam int WIDTH = 32;
    localparam int NREQ  = 4;

    typedef struct packed {
        logic [1:0]  id;
        logic        cout;
        logic [31:0] sum;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  t_valid = 4'b0;
    logic        t_rready = 1'b0;
    logic [31:0] opa [4];
    logic [31:0] opb [4];

    always #5 clk = ~clk;

    adder_rr_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

    assign bus.req_valid = t_valid;
    assign bus.res_ready = t_rready;
    assign bus.req_a     = {opa[3], opa[2], opa[1], opa[0]};
    assign bus.req_b     = {opb[3], opb[2], opb[1], opb[0]};

`ifdef ADDER_ARB_STATS_EN
    logic        stats_clr = 1'b0;
    logic [63:0] grant_cnt;
`endif

    adder_rr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus)
`ifdef ADDER_ARB_STATS_EN
        ,
        .stats_clr (stats_clr),
        .grant_cnt (grant_cnt)
`endif
    );

    int   checks = 0;
    int   failures = 0;
    int   m_ptr = 0;
    bit   m_vld = 1'b0;
    bit   rerand = 1'b0;
    exp_t sb [$];
    logic [3:0] last_rdy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check slot and grant against the model mid-cycle, then advance model and clock
    task automatic cyc();
        int         g;
        bit         free;
        logic [3:0] exp_rdy;
        #3;
        chk("res_valid", bus.res_valid, m_vld);
        if (m_vld) begin
            chk("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                chk("result", {bus.res_id, bus.res_cout, bus.res_sum}, sb[0]);
            end
        end
        free = !m_vld || t_rready;
        g = -1;
        for (int k = 0; k < 4; k++) begin
            if (g < 0 && t_valid[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
        end
        exp_rdy = (free && g >= 0) ? 4'(1 << g) : 4'b0;
        chk("req_ready", bus.req_ready, exp_rdy);
        last_rdy = bus.req_ready;
        if (m_vld && t_rready && sb.size() != 0) void'(sb.pop_front());
        if (exp_rdy != 4'b0) begin
            sb.push_back({2'(g), {1'b0, opa[g]} + {1'b0, opb[g]}});
            m_ptr = (g + 1) % 4;
            m_vld = 1'b1;
        end else if (t_rready) begin
            m_vld = 1'b0;
        end
        @(posedge clk);
        #1;
        if (exp_rdy != 4'b0 && rerand) begin
            opa[g] = $urandom;
            opb[g] = $urandom;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_sum", bus.res_sum, 0);
        chk("rst_res_cout", bus.res_cout, 0);
        chk("rst_res_id", bus.res_id, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_ptr = 0;
        m_vld = 1'b0;
        sb.delete();
    endtask

    initial begin
        logic [3:0] ord [5];
        int  xfers;
        bit  got3;
        bit  prev0;
        bit  double0;
        ord = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < 4; i++) begin
            opa[i] = '0;
            opb[i] = '0;
        end
        t_valid = 4'b1111;
        @(posedge clk);
        #1;
        do_reset();

        // Carry out of all-ones + 1 from requester 2
        t_valid  = 4'b0100;
        opa[2]   = 32'hFFFF_FFFF;
        opb[2]   = 32'h1;
        t_rready = 1'b1;
        cyc();
        chk("t1_grant", last_rdy, 4'b0100);
        chk("t1_valid", bus.res_valid, 1);
        chk("t1_sum", bus.res_sum, 0);
        chk("t1_cout", bus.res_cout, 1);
        chk("t1_id", bus.res_id, 2);
        t_valid = 4'b1111;
        cyc();
        chk("t1_ptr3", last_rdy, 4'b1000);

        // All valid from reset: strict rotation, no bubbles
        do_reset();
        for (int i = 0; i < 4; i++) begin
            opa[i] = $urandom;
            opb[i] = $urandom;
        end
        rerand = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t2_order", last_rdy, ord[i]);
            chk("t2_nobubble", bus.res_valid, 1);
        end

        // Backpressure hold then release with same-cycle regrant
        rerand  = 1'b0;
        t_valid = 4'b0010;
        opa[1]  = 32'd100;
        opb[1]  = 32'd23;
        cyc();
        t_valid  = 4'b1011;
        t_rready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t3_hold_sum", bus.res_sum, 123);
            chk("t3_hold_rdy", last_rdy, 0);
        end
        t_rready = 1'b1;
        cyc();
        chk("t3_regrant", last_rdy, 4'b1000);
        chk("t3_valid_kept", bus.res_valid, 1);

        // Fairness: req 0 hogging, req 3 joins later
        rerand  = 1'b1;
        t_valid = 4'b0001;
        repeat (10) cyc();
        t_valid = 4'b1001;
        xfers   = 0;
        got3    = 1'b0;
        prev0   = 1'b1;
        double0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (!got3 && last_rdy != 4'b0) begin
                xfers++;
                if (last_rdy[0] && prev0) double0 = 1'b1;
                prev0 = last_rdy[0];
                if (last_rdy[3]) got3 = 1'b1;
            end
        end
        chk("t4_req3_granted", got3, 1);
        chk("t4_within_nreq", xfers <= 4, 1);
        chk("t4_no_double0", double0, 0);

        // Asynchronous reset while the slot is stalled
        rerand  = 1'b0;
        t_valid = 4'b0100;
        cyc();
        t_valid  = 4'b0000;
        t_rready = 1'b0;
        cyc();
        chk("t5_stalled", bus.res_valid, 1);
        t_valid = 4'b1010;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_valid", bus.res_valid, 0);
        chk("t5_async_sum", bus.res_sum, 0);
        chk("t5_async_cout", bus.res_cout, 0);
        chk("t5_async_id", bus.res_id, 0);
        chk("t5_async_rdy", bus.req_ready, 0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        m_ptr    = 0;
        m_vld    = 1'b0;
        sb.delete();
        t_rready = 1'b1;
        cyc();
        chk("t5_first_grant", last_rdy, 4'b0010);
        t_valid = 4'b0000;
        cyc();
        cyc();

`ifdef ADDER_ARB_STATS_EN
        do_reset();
        t_valid  = 4'b0010;
        t_rready = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        chk("stats_sat1", grant_cnt[31:16], 16'hFFFF);
        chk("stats_idle0", grant_cnt[15:0], 0);
        chk("stats_idle3", grant_cnt[63:48], 0);
        stats_clr = 1'b1;
        @(posedge clk);
        #1;
        stats_clr = 1'b0;
        chk("stats_clr", grant_cnt, 0);
        t_valid = 4'b0000;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/adder_rr_arbiter.md
Name: adder_rr_arbiter

Overview:
Shares one carry-skip adder datapath among NREQ requesters using a fair round-robin grant. Each requester presents a valid/ready operand pair. The arbiter steers the winning pair into a single internal carry_skip instance and registers the sum, carry-out and requester id into a one-entry output slot with valid/ready flow control. It sits between multiple address/accumulate clients and the shared adder, so only one adder is built per cluster.

Parameters:
WIDTH, 32, operand/sum width; must be a multiple of 4 (carry_skip block size); elaboration error otherwise.
NREQ, 4, number of requesters; 2..16.
IDW, (localparam) clog2(NREQ), width of result id.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  NREQ  per-requester operand valid.
req_a  input  NREQ*WIDTH  packed operand A; requester i at [i*WIDTH +: WIDTH].
req_b  input  NREQ*WIDTH  packed operand B; same packing.
req_ready  output  NREQ  one-hot grant/accept; at most one bit high.
res_valid  output  1  output slot holds a result.
res_ready  input  1  downstream accepts result.
res_sum  output  WIDTH  registered a+b (mod 2^WIDTH), carry-in 0.
res_cout  output  1  registered carry-out.
res_id  output  IDW  index of requester that produced the result.

Behaviour:
- Reset (async assert, sync release): res_valid=0, res_sum=0, res_cout=0, res_id=0, rr pointer=0. req_ready is 0 while rst_n=0.
- slot_free = !res_valid || res_ready.
- Grant: search req_valid starting at pointer p, wrapping upward (p, p+1, …, NREQ-1, 0, …, p-1). The first set bit i wins. req_ready = onehot(i) & {NREQ{slot_free}}. If no valid, req_ready=0.
- req_ready is combinational from req_valid, res_valid, res_ready and the pointer. Requesters must not make req_valid depend on req_ready.
- Transfer on requester i when req_valid[i] && req_ready[i]. On the same edge:
  - res_sum/res_cout load carry_skip(req_a[i], req_b[i]).
  - res_id <= i; res_valid <= 1.
  - p <= (i+1) mod NREQ.
- Latency: 1 cycle, accept edge to res_valid high. Throughput: 1 result/cycle when res_ready is held high.
- Output handshake: result consumed when res_valid && res_ready. If there is no new transfer on that edge, res_valid <= 0.
- Stall: while res_valid=1 and res_ready=0:
  - res_* hold stable;
  - req_ready=0;
  - pointer holds.
- Simultaneous consume and accept: slot reloads; res_valid stays 1, with no bubble.
- Pointer advances only on a transfer, never on idle cycles. A requester holding valid is granted within NREQ transfers (starvation-free).
- Requesters must hold operands stable while valid and not yet accepted. The arbiter may switch grant between cycles only after a transfer.
- Datapath: one carry_skip #(.width(WIDTH)) instance fed by a NREQ:1 mux on the grant index. Sum/cout are captured only on transfer, never from idle mux inputs.
- Reset asserted mid-stall: pending result is discarded; after release, behaves as from power-up with pointer=0.

Optional Feature:
ADDER_ARB_STATS_EN
- Defined: adds output grant_cnt [NREQ*16-1:0]; counter i at [i*16 +: 16]. Counter i increments on each transfer from requester i and saturates at 16'hFFFF. All counters are reset to 0 by rst_n. Also adds input stats_clr (1): synchronous clear of all counters. A clear in the same cycle as a transfer wins, leaving the count at 0.
- Undefined: no grant_cnt or stats_clr ports and no counter logic; all other behaviour identical.

Test Plan:
- Reset then NREQ=4, only req 2 valid with a=32'hFFFF_FFFF, b=32'h1, res_ready=1 -> req_ready=4'b0100; next cycle res_valid=1, res_sum=0, res_cout=1, res_id=2, pointer=3.
- All four valid continuously, res_ready=1, from reset -> grants in order 0,1,2,3,0 on consecutive cycles; res_id follows one cycle later with no bubbles.
- Backpressure: res_ready=0 for 5 cycles with result a=100, b=23 held -> res_sum=123 stable, req_ready=0 throughout. Raise res_ready -> next grant issues that same cycle; res_valid stays 1 into the new result.
- Fairness: req 0 always valid, req 3 valid from cycle 10 -> req 3 granted within 4 transfers; req 0 is never granted twice consecutively while req 3 is waiting.
- Async reset mid-stall: rst_n low for 1 cycle with res_valid=1 -> res_valid=0 immediately (without a clock edge), outputs zero; the first grant after release goes to the lowest valid index.
- With ADDER_ARB_STATS_EN: 70000 transfers from req 1 -> grant_cnt[31:16]=16'hFFFF; stats_clr pulse -> all counters 0.
